mem_arbiter_responder: RTL
==========================

// Module: mem_arbiter_responder
// PURPOSE
//  Memory-side responder for the icache and dcache request ports. Arbitrates the two
//  caches onto one RAM port, drives the RAM request and returns iwait/dwait and load
//  data to the caches. Sits between both caches and the RAM model that reports ramstate_t.
//  Adds a request timeout, RAM-error reporting and alternating priority under contention.
// PARAMETERS
//  TIMEOUT   255           cycles a grant may wait for ACCESS before it is forced to complete
//  BAD_WORD  32'hBAD1BAD1  load value returned on an error or timeout completion
// PORTS
//  CLK       in   1        clock
//  RST       in   1        asynchronous reset, active-high
//  iREN      in   1        icache read request
//  iaddr     in   32       icache word address (word_t)
//  iwait     out  1        icache stall; low for exactly the completion cycle
//  iload     out  32       icache read data; valid when iwait is low
//  dREN      in   1        dcache read request
//  dWEN      in   1        dcache write request
//  daddr     in   32       dcache word address
//  dstore    in   32       dcache write data
//  dwait     out  1        dcache stall; low for exactly the completion cycle
//  dload     out  32       dcache read data; valid when dwait is low
//  ramREN    out  1        RAM read enable
//  ramWEN    out  1        RAM write enable
//  ramaddr   out  32       RAM address
//  ramstore  out  32       RAM write data
//  ramload   in   32       RAM read data
//  ramstate  in   2        ramstate_t: FREE/BUSY/ACCESS/ERROR
//  err       out  1        sticky: RAM ERROR or timeout seen since reset
// BEHAVIOUR
//  Reset (async, RST=1): state IDLE, iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0,
//  iload=dload=0, err=0, timeout counter=0, last_grant=I. All outputs decode from state.
//  FSM states: IDLE, D_SRV, I_SRV, DONE. One grant is registered per transaction.
//  IDLE: dreq=dREN|dWEN.
//    - dreq and no iREN -> D_SRV. iREN and no dreq -> I_SRV.
//    - Both -> grant opposite of last_grant.
//    - Neither -> stay. No RAM enables in IDLE.
//  D_SRV: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
//    - ramstate==ACCESS -> dwait=0 that cycle, dload=ramload (comb) -> DONE.
//    - ramstate==ERROR, or counter==TIMEOUT-1 -> dwait=0, dload=BAD_WORD, err<=1 -> DONE.
//    - dREN&dWEN both high: protocol error; treated as ERROR completion, no RAM enables driven.
//    - dREN=dWEN=0 (request dropped) -> IDLE next cycle, no completion pulse.
//  I_SRV: same rules with iREN/iaddr/iwait/iload; ramWEN always 0.
//  DONE: one dead cycle (enables low, both waits high) so the cache can deassert or
//  change its request; update last_grant; -> IDLE. Back-to-back latency: >=3 cycles.
//  Timeout counter: clears on entering D_SRV/I_SRV, +1 per cycle in service, saturating.
//  Minimum latency: grant registered in cycle 0, earliest wait-low in cycle 1.
//  Waits never low for the non-granted cache; never both low in one cycle.
//  err is set only by ERROR/timeout completions and cleared only by RST.
//  Reset mid-service: all enables drop asynchronously; no completion is reported.
// STRUCTURE
//  cpu_types_pkg gains: memarb_state_t enum (IDLE,D_SRV,I_SRV,DONE), grant_t enum (GNT_I,GNT_D).
//  Sub-module mem_timeout_cnt (clear, enable, saturate at TIMEOUT-1, expired flag).
//  Top: state/last_grant/err flops, next-state logic, output decode mux.
// TESTING
//  1 dREN, daddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0x1234 -> dwait low cycle 3,
//    dload=0x1234.
//  2 dWEN daddr=0x80 dstore=0xCAFE, ACCESS cycle 1 -> ramWEN=1, ramstore=0xCAFE;
//    dwait low one cycle.
//  3 iREN and dREN held together for 4 transactions -> grants D,I,D,I (last_grant reset=I).
//  4 ramstate=ERROR during I_SRV -> iwait low, iload=0xBAD1BAD1, err=1 until RST.
//  5 ramstate held BUSY, TIMEOUT=8 -> completion at service cycle 8, dload=BAD_WORD, err=1.
//  6 RST asserted mid D_SRV -> same cycle ramREN/ramWEN=0, dwait=1, state IDLE;
//    dREN dropped mid-service -> IDLE, no pulse.

Source files
------------

// File: rtl/mem_arbiter_responder_pkg.sv
// Shared types for the cache-to-RAM responder: RAM status, FSM states and grant owner.
package mem_arbiter_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, D_SRV, I_SRV, DONE} memarb_state_t;

  typedef enum logic {GNT_I, GNT_D} grant_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Service-cycle counter: cleared outside service, counts up while in service and saturates
// at Timeout-1, where expired_o is raised.
module mem_timeout_cnt #(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter_responder.sv
// Arbitrates icache and dcache onto a single RAM port, with timeout, sticky error reporting
// and alternating priority when both caches request at once.
module mem_arbiter_responder
  import mem_arbiter_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter word_t       BAD_WORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  memarb_state_t state_d, state_q;
  grant_t        last_grant_d, last_grant_q;
  logic          err_d, err_q;
  logic          dreq, in_srv, expired;

  assign dreq   = dREN | dWEN;
  assign in_srv = (state_q == D_SRV) || (state_q == I_SRV);

  mem_timeout_cnt #(
    .Timeout(TIMEOUT)
  ) u_timeout_cnt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (!in_srv),
    .en_i     (in_srv),
    .expired_o(expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    case (state_q)
      IDLE: begin
        if (dreq && iREN) begin
          state_d = (last_grant_q == GNT_I) ? D_SRV : I_SRV;
        end else if (dreq) begin
          state_d = D_SRV;
        end else if (iREN) begin
          state_d = I_SRV;
        end
      end
      D_SRV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // Simultaneous read and write is a cache protocol violation: fail it without RAM access.
        if (dREN && dWEN) begin
          dwait        = 1'b0;
          dload        = BAD_WORD;
          err_d        = 1'b1;
          last_grant_d = GNT_D;
          state_d      = DONE;
        end else if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramREN = dREN;
          ramWEN = dWEN;
          if (ramstate == ACCESS) begin
            dwait        = 1'b0;
            dload        = ramload;
            last_grant_d = GNT_D;
            state_d      = DONE;
          end else if ((ramstate == ERROR) || expired) begin
            dwait        = 1'b0;
            dload        = BAD_WORD;
            err_d        = 1'b1;
            last_grant_d = GNT_D;
            state_d      = DONE;
          end
        end
      end
      I_SRV: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramstate == ACCESS) begin
            iwait        = 1'b0;
            iload        = ramload;
            last_grant_d = GNT_I;
            state_d      = DONE;
          end else if ((ramstate == ERROR) || expired) begin
            iwait        = 1'b0;
            iload        = BAD_WORD;
            err_d        = 1'b1;
            last_grant_d = GNT_I;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule
